// File: rtl/kij_inst_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kij_inst_sequencer : issues the 34-bit core instruction word for every kij
// pass of a convolution (weight load, activation execute, psum writeback).
// Rev 1.0
// ----------------------------------------------------------------------------
module kij_inst_sequencer #(
  parameter int          col       = 8,
  parameter int          len_nij   = 36,
  parameter int          len_kij   = 9,
  parameter logic [10:0] W_BASE    = 11'h400,
  parameter logic [10:0] X_BASE    = 11'h000,
  parameter int          GAP_CYC   = 10,
  parameter int          DRAIN_CYC = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int AP_LSB     = 20;
  localparam int B_CEN_X    = 19;
  localparam int AX_LSB     = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  localparam logic [33:0] IDLE_WORD  = (34'd1 << B_CEN_P) | (34'd1 << B_WEN_P) |
                                       (34'd1 << B_CEN_X) | (34'd1 << 18);
  localparam logic [10:0] COL_N      = 11'(col);
  localparam logic [10:0] NIJ_N      = 11'(len_nij);
  localparam logic [10:0] GAP_LAST   = 11'(GAP_CYC - 1);
  localparam logic [10:0] DRAIN_LAST = 11'(DRAIN_CYC - 1);
  localparam logic [3:0]  KIJ_LAST   = 4'(len_kij - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W2L0, S_WLOAD, S_GAP, S_X2L0, S_EXEC, S_DRAIN, S_OFIFO, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] rd_cnt_q, rd_cnt_d;
  logic [10:0] wr_cnt_q, wr_cnt_d;
  logic [10:0] pbase_q, pbase_d;
  logic [3:0]  kij_q, kij_d;
  logic [33:0] inst_q, inst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_nxt, wr_nxt;

  // state_d/cnt_d describe the word presented after the next edge, so the
  // instruction fields are decoded from them to keep inst fully registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 11'd1;
    kij_d    = kij_q;
    pbase_d  = pbase_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_W2L0;
      end
      S_W2L0:  if (cnt_q == COL_N)      begin state_d = S_WLOAD; cnt_d = '0; end
      S_WLOAD: if (cnt_q == COL_N)      begin state_d = S_GAP;   cnt_d = '0; end
      S_GAP:   if (cnt_q == GAP_LAST)   begin state_d = S_X2L0;  cnt_d = '0; end
      S_X2L0:  if (cnt_q == NIJ_N)      begin state_d = S_EXEC;  cnt_d = '0; end
      S_EXEC:  if (cnt_q == NIJ_N)      begin state_d = S_DRAIN; cnt_d = '0; end
      S_DRAIN: if (cnt_q == DRAIN_LAST) begin state_d = S_OFIFO; cnt_d = '0; end
      S_OFIFO: begin
        cnt_d = '0;
        if (wr_cnt_q == NIJ_N) begin
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          if (kij_q == KIJ_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_W2L0;
            kij_d   = kij_q + 4'd1;
            pbase_d = pbase_q + NIJ_N;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        kij_d   = '0;
        pbase_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A psum write always follows the read shown on inst one cycle earlier.
    rd_nxt = (state_d == S_OFIFO) && ofifo_valid && (rd_cnt_q < NIJ_N);
    wr_nxt = (state_d == S_OFIFO) && inst_q[B_OFIFO_RD];
    if (rd_nxt) rd_cnt_d = rd_cnt_q + 11'd1;
    if (wr_nxt) wr_cnt_d = wr_cnt_q + 11'd1;

    inst_d = IDLE_WORD;
    case (state_d)
      S_W2L0: begin
        if (cnt_d < COL_N) begin
          inst_d[B_CEN_X]      = 1'b0;
          inst_d[AX_LSB +: 11] = W_BASE + cnt_d;
        end
        inst_d[B_L0_WR] = (cnt_d != '0);
      end
      S_WLOAD: begin
        inst_d[B_L0_RD] = (cnt_d < COL_N);
        inst_d[B_LOAD]  = (cnt_d != '0);
      end
      S_X2L0: begin
        if (cnt_d < NIJ_N) begin
          inst_d[B_CEN_X]      = 1'b0;
          inst_d[AX_LSB +: 11] = X_BASE + cnt_d;
        end
        inst_d[B_L0_WR] = (cnt_d != '0);
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = (cnt_d < NIJ_N);
        inst_d[B_EXEC]  = (cnt_d != '0);
      end
      S_OFIFO: begin
        inst_d[B_OFIFO_RD] = rd_nxt;
        if (wr_nxt) begin
          inst_d[B_CEN_P]      = 1'b0;
          inst_d[B_WEN_P]      = 1'b0;
          inst_d[AP_LSB +: 11] = pbase_q + wr_cnt_q;
        end
      end
      default: inst_d = IDLE_WORD;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      pbase_q  <= '0;
      kij_q    <= '0;
      inst_q   <= IDLE_WORD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      pbase_q  <= pbase_d;
      kij_q    <= kij_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign kij  = kij_q;

endmodule
`default_nettype wire

// File: doc/kij_inst_sequencer.md
# kij_inst_sequencer

Sequences the 34-bit `inst` word that drives `core` through all nine kernel-position (kij) passes of a convolution. Per pass it stages weights X_MEM→L0→PE, streams activations X_MEM→L0→PE with execute, drains, then moves OFIFO psums into P_MEM at a per-kij offset. It sits directly upstream of `core` and issues the instruction stream that otherwise has to be hand-stepped cycle by cycle.

## Interface
Parameters:
- `col`, 8: PE columns; weight words per kij.
- `len_nij`, 36: activation words per pass; psum words written per pass.
- `len_kij`, 9: number of kij passes.
- `W_BASE`, 11'h400: X_MEM address of the first weight word.
- `X_BASE`, 11'h000: X_MEM address of the first activation word.
- `GAP_CYC`, 10: idle cycles after the kernel load.
- `DRAIN_CYC`, 12: idle cycles after the last execute.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on `clk`.
- `start`  in  1  one-cycle pulse that begins a full run when the block is idle.
- `ofifo_valid`  in  1  the core's OFIFO holds a readable row.
- `inst`  out  34  registered instruction word. Bit fields, MSB first: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the last psum of kij = `len_kij`-1 is written.
- `kij`  out  4  index of the current pass.

## Operation
- IDLE word: CEN/WEN (xmem and pmem) = 1; both addresses 0; acc, ififo_wr, ififo_rd, and all strobes = 0. acc, ififo_wr and ififo_rd are always 0 in this block.
- FSM states: IDLE → W2L0 → WLOAD → GAP → X2L0 → EXEC → DRAIN → OFIFO → (next kij: W2L0 | last kij: DONE) → IDLE.
- W2L0: `col` cycles with CEN_xmem=0, WEN_xmem=1, A_xmem = W_BASE+i for i = 0..col-1. l0_wr mirrors the read strobe delayed by 1 cycle, because SRAM read latency is 1. The state exits after the trailing l0_wr cycle.
- WLOAD: l0_rd is high for `col` cycles. load is high for `col` cycles, starting 1 cycle after the first l0_rd.
- GAP: the IDLE word is driven for `GAP_CYC` cycles.
- X2L0: identical to W2L0, but for `len_nij` reads starting at A_xmem = X_BASE.
- EXEC: l0_rd is high for `len_nij` cycles. execute is high for `len_nij` cycles, delayed by 1 cycle from l0_rd.
- DRAIN: the IDLE word is driven for `DRAIN_CYC` cycles.
- OFIFO: ofifo_rd = ofifo_valid && (rd_cnt < len_nij).
  - One cycle after each ofifo_rd: CEN_pmem=0, WEN_pmem=0, A_pmem = kij*len_nij + wr_cnt.
  - The state exits when wr_cnt reaches len_nij.
  - While ofifo_valid is low, ofifo_rd and the pmem write strobes stall at 0. There is no timeout.
- A_pmem arithmetic: computed at 11 bits, with kij*len_nij formed from a running base (+len_nij per pass), not a multiplier. With defaults the maximum address is 8*36+35 = 323.
- kij increments on the OFIFO→W2L0 transition and holds at len_kij-1 through DONE.
- DONE: asserts `done` for 1 cycle with the IDLE word, then returns to IDLE. `kij` returns to 0 in IDLE.

## Timing
- `start` is sampled in IDLE. The first W2L0 word appears on `inst` the next cycle, and `busy` rises in the same cycle.
- `start` received while busy is ignored.
- Reset values: `inst` = IDLE word, `busy`=0, `done`=0, `kij`=0, all counters 0.
- Reset low mid-run: at the next edge all outputs take their reset values and the run is abandoned. No pmem write completes after the reset edge.
- Pass length with ofifo_valid held high: (col+1) + (col+1) + GAP_CYC + (len_nij+1) + (len_nij+1) + DRAIN_CYC + (len_nij+1) cycles.
  - With defaults this is 9+9+10+37+37+12+37 = 151 cycles.
  - A full run is 9*151 = 1359 cycles, followed by the 1-cycle DONE.
- There is never more than one outstanding pmem write. A_pmem is contiguous within a pass: no gaps and no wrap.

## Test plan
- Reset held low for 3 cycles, then released with no `start` → `inst` = IDLE word (bits 32,31,19,18 = 1, all other bits 0); `busy`=0, `done`=0.
- `start` pulse with ofifo_valid tied high → `done` rises exactly 1359 cycles after `busy` rises. Across the run, load is counted 72 times (9×8), execute 324 times, and pmem writes 324 times.
- Pass 0 field trace:
  - A_xmem sequence is 400h..407h, then 000h..023h.
  - l0_wr trails CEN_xmem=0 by exactly 1 cycle.
  - load trails l0_rd by 1 cycle; execute trails l0_rd by 1 cycle.
- OFIFO stall: ofifo_valid toggles 1/0 every 3 cycles during kij=3 → 36 writes occur at A_pmem 108..143 in order. No write occurs while stalled, and no address is duplicated.
- Reset driven low in EXEC of kij=5 → `inst` returns to the IDLE word on the next edge, with `busy`=0 and `kij`=0. A subsequent `start` replays from kij=0, A_xmem=400h.
- `start` re-pulsed while busy (during GAP of kij=1) → no effect: the cycle count and address trace are identical to an undisturbed run.
